// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: FSM state encodings, width defaults, port indices.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 16;

    localparam logic P_CPU = 1'b0;
    localparam logic P_DBG = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: the requester that was not served last wins a tie.
module mem_arbiter_rr_pick2 (
    input  logic [1:0] eligible_i,
    input  logic       last_i,
    output logic       grant_valid_o,
    output logic       grant_idx_o
);

    always_comb begin
        grant_valid_o = |eligible_i;
        grant_idx_o   = 1'b0;
        unique case (eligible_i)
            2'b01:   grant_idx_o = 1'b0;
            2'b10:   grant_idx_o = 1'b1;
            2'b11:   grant_idx_o = ~last_i;
            default: grant_idx_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU (port 0) and debug (port 1) accesses onto one synchronous single-port RAM.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    // mem_we clears before the response cycle, so the op type is kept separately
    logic              op_we_q, op_we_d;

    logic [1:0]        eligible;
    logic              grant_valid;
    logic              grant_idx;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              resp0;
    logic              resp1;

    // The port being acked is never eligible in the same cycle.
    always_comb begin
        eligible = {req1, req0};
        if (state_q == StResp) begin
            eligible[owner_q] = 1'b0;
        end else if (state_q == StIssue) begin
            eligible = 2'b00;
        end
    end

    mem_arbiter_rr_pick2 u_pick (
        .eligible_i    (eligible),
        .last_i        (last_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    assign sel_we    = (grant_idx == P_DBG) ? we1    : we0;
    assign sel_addr  = (grant_idx == P_DBG) ? addr1  : addr0;
    assign sel_wdata = (grant_idx == P_DBG) ? wdata1 : wdata0;

    always_comb begin
        state_d     = state_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        owner_d     = owner_q;
        last_d      = last_q;
        op_we_d     = op_we_q;
        unique case (state_q)
            StIdle, StResp: begin
                if (state_q == StResp) begin
                    last_d  = owner_q;
                    state_d = StIdle;
                end
                if (grant_valid) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    owner_d     = grant_idx;
                    op_we_d     = sel_we;
                    state_d     = StIssue;
                end
            end
            StIssue: state_d = StResp;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            owner_q     <= P_CPU;
            last_q      <= P_DBG;
            op_we_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            op_we_q     <= op_we_d;
        end
    end

    assign resp0 = (state_q == StResp) && (owner_q == P_CPU);
    assign resp1 = (state_q == StResp) && (owner_q == P_DBG);

    assign ack0      = resp0;
    assign ack1      = resp1;
    assign rdata0    = (resp0 && !op_we_q) ? mem_rdata : '0;
    assign rdata1    = (resp1 && !op_we_q) ? mem_rdata : '0;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM attached.
module tb_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        req0, req1, we0, we1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;

    logic [15:0] ram [256];

    int n_checks;
    int n_pass;

    mem_arbiter #(
        .ADDR_W (8),
        .DATA_W (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        ram[8'h01] = 16'h6000;
        ram[8'h20] = 16'h1111;
        mem_rdata  = 16'h0000;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

        // Reset state
        reset_n = 1'b0;
        tick();
        tick();
        check("rst_outputs", {30'd0, busy, mem_en}, 32'd0);
        check("rst_mem_regs", {8'd0, mem_we, 7'd0, mem_addr, mem_wdata}, 32'd0);
        check("rst_acks", {ack1, ack0, rdata1[14:0], rdata0[14:0]}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Port 0 read of address 0x01
        req0 = 1; we0 = 0; addr0 = 8'h01;
        tick();
        check("rd0_issue_en", {31'd0, mem_en}, 32'd1);
        check("rd0_issue_addr", {24'd0, mem_addr}, 32'h01);
        check("rd0_issue_noack", {30'd0, ack1, ack0}, 32'd0);
        tick();
        check("rd0_ack", {30'd0, ack1, ack0}, 32'b01);
        check("rd0_rdata", {16'd0, rdata0}, 32'h6000);
        check("rd0_rdata1_zero", {16'd0, rdata1}, 32'h0);
        req0 = 0;
        tick();
        check("rd0_idle", {29'd0, busy, ack1, ack0}, 32'd0);

        // Port 1 write then read back
        req1 = 1; we1 = 1; addr1 = 8'h14; wdata1 = 16'h0352;
        tick();
        check("wr1_issue", {14'd0, mem_en, mem_we, mem_wdata}, {14'd0, 2'b11, 16'h0352});
        tick();
        check("wr1_ack", {30'd0, ack1, ack0}, 32'b10);
        check("wr1_rdata_zero", {16'd0, rdata1}, 32'h0);
        check("wr1_we_cleared", {31'd0, mem_we}, 32'd0);
        req1 = 0;
        tick();
        req1 = 1; we1 = 0;
        tick();
        tick();
        check("rd1_ack", {30'd0, ack1, ack0}, 32'b10);
        check("rd1_rdata", {16'd0, rdata1}, 32'd850);
        req1 = 0;
        tick();

        // Simultaneous requests straight after reset: port 0 first
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        req0 = 1; we0 = 0; addr0 = 8'h01;
        req1 = 1; we1 = 0; addr1 = 8'h14;
        tick();
        check("tie_issue_addr", {24'd0, mem_addr}, 32'h01);
        tick();
        check("tie_ack0", {30'd0, ack1, ack0}, 32'b01);
        check("tie_rdata0", {16'd0, rdata0}, 32'h6000);
        req0 = 0;
        tick();
        check("tie_b2b_issue", {23'd0, mem_en, mem_addr}, {23'd0, 1'b1, 8'h14});
        check("tie_b2b_noack", {30'd0, ack1, ack0}, 32'd0);
        tick();
        check("tie_ack1", {30'd0, ack1, ack0}, 32'b10);
        check("tie_rdata1", {16'd0, rdata1}, 32'h0352);
        req1 = 0;
        tick();

        // Both ports hold requests for six accesses: alternate 0,1,0,1,0,1
        req0 = 1; req1 = 1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("rr_step%0d", i), {30'd0, ack1, ack0},
                  (i % 4 == 2) ? 32'b01 : ((i % 4 == 0) ? 32'b10 : 32'b00));
        end
        req0 = 0; req1 = 0;
        tick();
        check("rr_idle", {31'd0, busy}, 32'd0);

        // Reset during ISSUE aborts a port 1 write
        req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 16'hBEEF;
        tick();
        check("abort_issue_we", {31'd0, mem_we}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_async_ctl", {29'd0, mem_en, mem_we, busy}, 32'd0);
        check("abort_async_regs", {8'd0, mem_addr, mem_wdata}, 32'd0);
        check("abort_no_ack", {30'd0, ack1, ack0}, 32'd0);
        req1 = 0; we1 = 0;
        tick();
        reset_n = 1'b1;
        tick();
        check("abort_no_ack_later", {30'd0, ack1, ack0}, 32'd0);
        check("abort_ram_kept", {16'd0, ram[8'h20]}, 32'h1111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-port 16-bit program/data RAM between the CPU (port 0) and a debug/loader requester (port 1, e.g. switch-driven memory inspect/poke). It serialises accesses, issues each to the RAM with registered controls, and returns read data with a one-cycle ack. It sits inside `top` between `CPU`, the debug requester, and `MEM`.

## Interface
- ADDR_W, 8, RAM word-address width
- DATA_W, 16, RAM word width
- clk  in  1  rising-edge clock (CLOCK_50 at top)
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- req0 / req1  in  1  port request; held high until that port's ack
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  ADDR_W  word address; stable while req high
- wdata0 / wdata1  in  DATA_W  write data; stable while req high
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DATA_W  read data, valid only while own ack high; else 0
- mem_en  out  1  RAM access enable (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM synchronous read data, valid cycle after mem_en
- busy  out  1  high in ISSUE or RESP

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: if any req eligible, pick winner, latch its we/addr/wdata into mem_* regs, set mem_en=1, record `owner`, -> ISSUE; else stay, mem_en=0.
- ISSUE: RAM executes at end of cycle. -> RESP; mem_en/mem_we cleared at that edge.
- RESP: ack<owner>=1, rdata<owner>=mem_rdata (writes: rdata = 0). Update `last` = owner. Requester `owner` is ineligible this cycle (its req is the completed one). If other port's req high -> latch it, -> ISSUE (back-to-back); else -> IDLE.
- Arbitration: 2-way round-robin. Both eligible -> port != `last` wins. Single eligible -> it wins.
- Writes commit once, at the ISSUE->RESP edge. No reordering; one access in flight.
- A port dropping req before its ack is a protocol violation; arbiter completes the access anyway and still pulses ack.

## Timing
- Reset (async, reset_n=0): state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, ack0=ack1=0, rdata*=0, busy=0, last=1 (port 0 wins first tie).
- Latency: req sampled high in cycle N (IDLE) -> mem_en high N+1 -> ack + rdata in N+2.
- Throughput: one access per 2 cycles under contention; alternating ports when both stay requesting.
- Same port requesting again immediately after ack, other idle: RESP->IDLE, new req accepted next cycle (3-cycle spacing).
- Reset asserted in ISSUE: mem_we drops asynchronously before the edge; write not committed; no ack issued.
- Reset asserted in RESP: ack drops immediately; requester must re-request.
- Address wrap: none; ADDR_W bits passed through unchanged.

## Structure
- Shared package/include `mem_defs`: state encodings (IDLE, ISSUE, RESP), ADDR_W/DATA_W defaults, port index constants (P_CPU=0, P_DBG=1).
- One sub-module natural: `rr_pick2` (inputs eligible[1:0], last; outputs grant_valid, grant_idx), combinational, reused by future multi-master blocks.
- Datapath registers: mem_* regs, owner, last, state.

## Test plan
- Reset then port 0 read addr 0x01 (RAM holds 0x6000) -> mem_en high cycle 1, ack0 cycle 2 with rdata0=0x6000, ack1 never.
- Port 1 write 0x14 <= 0x0352, then read 0x14 -> write acked cycle 2, read returns rdata1=0x0352 (decimal 850).
- req0 and req1 both raised same cycle after reset -> port 0 acked first (cycle 2), port 1 issued back-to-back, acked cycle 4.
- Both ports hold req for 6 accesses -> ack order 0,1,0,1,0,1, one ack every 2 cycles.
- Port 1 write 0xBEEF to addr 0x20, reset_n pulsed low during ISSUE -> all outputs 0 immediately, mem[0x20] unchanged, no ack1.
- CPU-driven program from RAM runs to HALT with debug port idle -> identical PC/register/memory results as direct RAM connection.
